// File: rtl/misc_rr_sched_if.sv
// Scheduler-side bundle for the 4-in/4-out FIFO crossbar: FIFO status flags
// in, crossbar select and FIFO strobes out. The master modport is the
// scheduler, the slave modport is the FIFO/crossbar side.
// Optional feature macro: MISC_ARB_STATS_EN (adds word_cnt).
interface misc_rr_sched_if #(
    parameter int STAT_W = 16
);
    logic [3:0] fifo_empty;   // empty flags of input FIFOs 0-3
    logic [7:0] head_dest;    // {dest3,dest2,dest1,dest0}
    logic [3:0] fifo_full;    // full flags of output FIFOs 0-3
    logic [1:0] demux0;       // crossbar input select
    logic [3:0] pop;          // one-hot input FIFO read strobe
    logic [3:0] push;         // one-hot output FIFO write strobe
    logic       busy;         // scheduler not idle
`ifdef MISC_ARB_STATS_EN
    logic [STAT_W-1:0] word_cnt;  // forwarded-word counter
`endif

    modport master (
        input  fifo_empty, head_dest, fifo_full,
`ifdef MISC_ARB_STATS_EN
        output word_cnt,
`endif
        output demux0, pop, push, busy
    );

    modport slave (
        output fifo_empty, head_dest, fifo_full,
`ifdef MISC_ARB_STATS_EN
        input  word_cnt,
`endif
        input  demux0, pop, push, busy
    );
endinterface

// File: rtl/misc_rr_sched.sv
// Round-robin scheduler for the 4-in/4-out FIFO crossbar.
// Moves one word per XFER cycle from the granted input FIFO to the output FIFO
// named by the head word's dest field, up to BURST_MAX words per grant, with a
// GAP cycle after every transfer so the FIFO flags can settle.
// Strobes are decoded from registered state only (no input-to-output paths).
// Optional feature macro: MISC_ARB_STATS_EN adds the word_cnt statistics counter.
module misc_rr_sched #(
    parameter int BURST_MAX = 4,   // 1..15 words per grant
    parameter int STAT_W    = 16   // word_cnt width
) (
    input  logic             clk,
    input  logic             reset,
    misc_rr_sched_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [3:0] LP_BURST_MAX = 4'(BURST_MAX);

    state_t     r_state;
    logic [1:0] r_sel;        // granted input, drives demux0
    logic [1:0] r_dst;        // output FIFO of the word being moved
    logic [1:0] r_ptr;        // last input served; scan starts after it
    logic [3:0] r_burst_cnt;  // words taken in the current grant

    state_t     w_next_state;
    logic [1:0] w_next_sel;
    logic [1:0] w_next_dst;
    logic [1:0] w_next_ptr;
    logic [3:0] w_next_burst;
    logic [3:0] w_elig;
    logic [1:0] w_idx;
    logic       w_found;

    // Input i may move a word when it holds one and its destination has room
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = ~bus.fifo_empty[i] & ~bus.fifo_full[bus.head_dest[2*i +: 2]];
        end
    end

    // Next-state logic: round-robin scan in GRANT, burst continuation in GAP
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_next_dst   = r_dst;
        w_next_ptr   = r_ptr;
        w_next_burst = r_burst_cnt;
        w_found      = 1'b0;
        w_idx        = '0;
        unique case (r_state)
            IDLE: begin
                if (|w_elig) begin
                    w_next_state = GRANT;
                end
            end
            GRANT: begin
                w_next_state = IDLE;
                // k=4 wraps back to ptr itself, so a lone requester is regranted
                for (int k = 1; k <= 4; k++) begin
                    w_idx = r_ptr + 2'(k);
                    if (!w_found && w_elig[w_idx]) begin
                        w_found      = 1'b1;
                        w_next_sel   = w_idx;
                        w_next_dst   = bus.head_dest[{w_idx, 1'b0} +: 2];
                        w_next_burst = '0;
                        w_next_state = XFER;
                    end
                end
            end
            XFER: begin
                w_next_ptr   = r_sel;
                w_next_burst = (r_burst_cnt < LP_BURST_MAX) ? r_burst_cnt + 4'd1 : r_burst_cnt;
                w_next_state = GAP;
            end
            GAP: begin
                if ((r_burst_cnt < LP_BURST_MAX) && w_elig[r_sel]) begin
                    w_next_dst   = bus.head_dest[{r_sel, 1'b0} +: 2];
                    w_next_state = XFER;
                end else begin
                    w_next_state = GRANT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register with synchronous reset; ptr=3 makes input 0 first in line
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_dst       <= '0;
            r_ptr       <= 2'd3;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_sel       <= w_next_sel;
            r_dst       <= w_next_dst;
            r_ptr       <= w_next_ptr;
            r_burst_cnt <= w_next_burst;
        end
    end

    // Moore outputs: pop and push share the XFER condition, so never split
    assign bus.demux0 = r_sel;
    assign bus.pop    = (r_state == XFER) ? (4'b0001 << r_sel) : 4'b0000;
    assign bus.push   = (r_state == XFER) ? (4'b0001 << r_dst) : 4'b0000;
    assign bus.busy   = (r_state != IDLE);

`ifdef MISC_ARB_STATS_EN
    logic [STAT_W-1:0] r_word_cnt;

    // Forwarded-word counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_cnt <= '0;
        end else if (r_state == XFER) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    assign bus.word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_misc_rr_sched.sv
// Bench for misc_rr_sched. Two instances: dut_a with BURST_MAX=4 and dut_b
// with BURST_MAX=1. Each has a word-count model of its input FIFOs; expected
// transfers are queued when stimulus is loaded and a per-instance monitor
// compares every strobe cycle against the queue head.
module tb_misc_rr_sched;

    typedef struct packed {
        logic [1:0] demux;
        logic [3:0] pop;
        logic [3:0] push;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] head_dest = 8'h00;
    logic [3:0] full = 4'h0;
    int cnt_a [4];
    int cnt_b [4];
    int checks = 0;
    int failures = 0;
    exp_t q_a [$];
    exp_t q_b [$];
`ifdef MISC_ARB_STATS_EN
    logic [15:0] wc_before;
`endif

    always #5 clk = ~clk;

    misc_rr_sched_if #(.STAT_W(16)) bus_a ();
    misc_rr_sched_if #(.STAT_W(16)) bus_b ();

    misc_rr_sched #(.BURST_MAX(4), .STAT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    misc_rr_sched #(.BURST_MAX(1), .STAT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    assign bus_a.head_dest = head_dest;
    assign bus_b.head_dest = head_dest;
    assign bus_a.fifo_full = full;
    assign bus_b.fifo_full = full;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus_a.fifo_empty[i] = (cnt_a[i] == 0);
            bus_b.fifo_empty[i] = (cnt_b[i] == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: any strobe cycle must match the next queued transfer
    always @(negedge clk) begin
        if ((bus_a.pop | bus_a.push) != 4'h0) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_xfer", {22'h0, bus_a.demux0, bus_a.pop, bus_a.push}, 32'h0);
            end else begin
                check("a_xfer", {22'h0, bus_a.demux0, bus_a.pop, bus_a.push}, {22'h0, q_a.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if ((bus_b.pop | bus_b.push) != 4'h0) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_xfer", {22'h0, bus_b.demux0, bus_b.pop, bus_b.push}, 32'h0);
            end else begin
                check("b_xfer", {22'h0, bus_b.demux0, bus_b.pop, bus_b.push}, {22'h0, q_b.pop_front()});
            end
        end
    end

    // Advance one clock; the FIFO models consume a word for every pop seen
    task automatic step(input int n);
        logic [3:0] pa;
        logic [3:0] pb;
        repeat (n) begin
            pa = bus_a.pop;
            pb = bus_b.pop;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (pa[i] && cnt_a[i] > 0) cnt_a[i]--;
                if (pb[i] && cnt_b[i] > 0) cnt_b[i]--;
            end
        end
    endtask

    // Bounded wait for all queued transfers, then a few quiet cycles
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        check(name, q_a.size() + q_b.size(), 0);
        step(6);
    endtask

    task automatic exp_a(input logic [1:0] d, input logic [3:0] p, input logic [3:0] w);
        exp_t e;
        e.demux = d; e.pop = p; e.push = w;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input logic [1:0] d, input logic [3:0] p, input logic [3:0] w);
        exp_t e;
        e.demux = d; e.pop = p; e.push = w;
        q_b.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end

        // 1: reset with everything empty, then stay idle
        #1;
        step(2);
        check("rst_demux0", bus_a.demux0, 2'd0);
        check("rst_pop", bus_a.pop, 4'h0);
        check("rst_push", bus_a.push, 4'h0);
        check("rst_busy", bus_a.busy, 1'b0);
`ifdef MISC_ARB_STATS_EN
        check("rst_word_cnt", bus_a.word_cnt, 16'd0);
`endif
        reset = 1'b0;
        step(4);
        check("idle_busy_a", bus_a.busy, 1'b0);
        check("idle_busy_b", bus_b.busy, 1'b0);

        // 2: single word on input 1 to output 2, 2-cycle latency
        head_dest = 8'b00_00_10_00;
        cnt_a[1] = 1;
        exp_a(2'd1, 4'b0010, 4'b0100);
        step(1);
        check("t2_grant_busy", bus_a.busy, 1'b1);
        step(1);
        check("t2_pop_latency", bus_a.pop, 4'b0010);
        check("t2_demux0", bus_a.demux0, 2'd1);
        step(3);
        check("t2_back_to_idle", bus_a.busy, 1'b0);
        drain("t2_drain");

        // 3: BURST_MAX=1 rotates 0,1,2,3,0
        head_dest = 8'h00;
        cnt_b[0] = 2; cnt_b[1] = 1; cnt_b[2] = 1; cnt_b[3] = 1;
        exp_b(2'd0, 4'b0001, 4'b0001);
        exp_b(2'd1, 4'b0010, 4'b0001);
        exp_b(2'd2, 4'b0100, 4'b0001);
        exp_b(2'd3, 4'b1000, 4'b0001);
        exp_b(2'd0, 4'b0001, 4'b0001);
        drain("t3_drain");
        check("t3_b_idle", bus_b.busy, 1'b0);

        // 4: input 2 blocked by full output 3 until full clears
        head_dest = 8'b00_11_00_00;
        full = 4'b1000;
        cnt_a[0] = 2; cnt_a[2] = 1;
        exp_a(2'd0, 4'b0001, 4'b0001);
        exp_a(2'd0, 4'b0001, 4'b0001);
        drain("t4_drain_blocked");
        check("t4_blocked_idle", bus_a.busy, 1'b0);
        check("t4_input2_waiting", cnt_a[2], 1);
        exp_a(2'd2, 4'b0100, 4'b1000);
        full = 4'b0000;
        drain("t4_drain_unblocked");

        // 5: six words on input 0, burst of 4 then regrant for 2
        head_dest = 8'h00;
`ifdef MISC_ARB_STATS_EN
        wc_before = bus_a.word_cnt;
`endif
        cnt_a[0] = 6;
        repeat (6) exp_a(2'd0, 4'b0001, 4'b0001);
        drain("t5_drain");
        check("t5_words_left", cnt_a[0], 0);
`ifdef MISC_ARB_STATS_EN
        check("t5_word_cnt", bus_a.word_cnt - wc_before, 16'd6);
`endif

        // 6: reset during XFER, then input 0 wins first
        cnt_a[2] = 3;
        exp_a(2'd2, 4'b0100, 4'b0001);
        for (int n = 0; n < 10 && bus_a.pop == 4'h0; n++) step(1);
        check("t6_xfer_seen", bus_a.pop, 4'b0100);
        reset = 1'b1;
        step(1);
        check("t6_rst_pop", bus_a.pop, 4'h0);
        check("t6_rst_push", bus_a.push, 4'h0);
        check("t6_rst_demux0", bus_a.demux0, 2'd0);
        check("t6_rst_busy", bus_a.busy, 1'b0);
`ifdef MISC_ARB_STATS_EN
        check("t6_rst_word_cnt", bus_a.word_cnt, 16'd0);
`endif
        step(1);
        cnt_a[0] = 1;
        exp_a(2'd0, 4'b0001, 4'b0001);
        exp_a(2'd2, 4'b0100, 4'b0001);
        exp_a(2'd2, 4'b0100, 4'b0001);
        reset = 1'b0;
        drain("t6_drain");
        check("t6_final_idle", bus_a.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
